// File: rtl/arith_issue_queue_if.sv
// arith_issue_queue_if: dispatch, wakeup, recall and issue signals of the ALU issue queue.
// Lane 0 of every two-lane bundle is the older instruction.
interface arith_issue_queue_if #(
    parameter int AW = 5,
    parameter int REG_W = 6
);
    logic [1:0] disp_valid;
    logic disp_ready;
    logic [1:0][3:0] disp_alu_op;
    logic [1:0][REG_W-1:0] disp_rs1;
    logic [1:0][REG_W-1:0] disp_rs2;
    logic [1:0] disp_rs1_rdy;
    logic [1:0] disp_rs2_rdy;
    logic [1:0] disp_uses_imm;
    logic [1:0][31:0] disp_imm;
    logic [1:0][REG_W-1:0] disp_rd;
    logic [1:0] disp_uses_rd;
    logic [1:0][AW-1:0] disp_al_addr;
    logic [1:0] wb_valid;
    logic [1:0][REG_W-1:0] wb_rd;
    logic [1:0] wb_uses_rd;
    logic if_recall;
    logic [AW-1:0] new_front;
    logic [AW-1:0] back;
    logic [1:0] iss_valid;
    logic [1:0][3:0] iss_alu_op;
    logic [1:0][REG_W-1:0] iss_rs1;
    logic [1:0][REG_W-1:0] iss_rs2;
    logic [1:0] iss_uses_imm;
    logic [1:0][31:0] iss_imm;
    logic [1:0][REG_W-1:0] iss_rd;
    logic [1:0] iss_uses_rd;
    logic [1:0][AW-1:0] iss_al_addr;

    modport master (
        output disp_valid, disp_alu_op, disp_rs1, disp_rs2, disp_rs1_rdy, disp_rs2_rdy,
               disp_uses_imm, disp_imm, disp_rd, disp_uses_rd, disp_al_addr,
               wb_valid, wb_rd, wb_uses_rd, if_recall, new_front, back,
        input  disp_ready, iss_valid, iss_alu_op, iss_rs1, iss_rs2, iss_uses_imm, iss_imm,
               iss_rd, iss_uses_rd, iss_al_addr
    );

    modport slave (
        input  disp_valid, disp_alu_op, disp_rs1, disp_rs2, disp_rs1_rdy, disp_rs2_rdy,
               disp_uses_imm, disp_imm, disp_rd, disp_uses_rd, disp_al_addr,
               wb_valid, wb_rd, wb_uses_rd, if_recall, new_front, back,
        output disp_ready, iss_valid, iss_alu_op, iss_rs1, iss_rs2, iss_uses_imm, iss_imm,
               iss_rd, iss_uses_rd, iss_al_addr
    );
endinterface

// File: rtl/arith_issue_queue.sv
// arith_issue_queue: dual-dispatch, dual-issue wakeup/select queue for integer ALU ops.
// Entries carry a wrapping age stamp; the two oldest ready entries issue each cycle.
module arith_issue_queue #(
    parameter int DEPTH = 8,
    parameter int AL_SIZE = 32,
    parameter int REG_W = 6
) (
    input logic clk,
    input logic rst,
    arith_issue_queue_if.slave io
);
    localparam int AW = $clog2(AL_SIZE);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam int GW = 16;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic rs1_rdy;
        logic rs2_rdy;
        logic uses_imm;
        logic [31:0] imm;
        logic [REG_W-1:0] rd;
        logic uses_rd;
        logic [AW-1:0] al;
        logic [GW-1:0] age;
    } entry_t;

    logic [DEPTH-1:0] valid;
    entry_t ent [DEPTH];
    logic [CW-1:0] count;
    logic [GW-1:0] age_ctr;
    logic [DEPTH-1:0] elig, first, second, sq, rm;
    logic [CW-1:0] rank [DEPTH];
    logic [IW-1:0] sel [2];
    logic [1:0] found, go, we;
    logic [IW-1:0] f0, f1;
    logic [IW-1:0] slot [2];
    entry_t new_ent [2];
    logic [CW-1:0] n_disp, n_rm;

    function automatic logic woke(input logic [REG_W-1:0] tag);
        woke = tag == '0;
        for (int k = 0; k < 2; k++)
            woke |= io.wb_valid[k] && io.wb_uses_rd[k] && io.wb_rd[k] == tag;
    endfunction

    function automatic logic squashed(input logic [AW-1:0] al);
        logic [AW-1:0] off, len;
        off = al - io.new_front;
        len = io.back - io.new_front;
        squashed = io.if_recall && off < len;
    endfunction

    // Sign of the wrapped difference orders stamps as long as live entries span < 2^(GW-1).
    function automatic logic older(input logic [GW-1:0] a, input logic [GW-1:0] b);
        logic [GW-1:0] d;
        d = a - b;
        older = d[GW-1];
    endfunction

    assign io.disp_ready = count <= CW'(DEPTH - 2);

    always_comb begin
        elig = '0;
        sq = '0;
        first = '0;
        second = '0;
        sel[0] = '0;
        sel[1] = '0;
        n_rm = '0;
        for (int i = 0; i < DEPTH; i++) begin
            elig[i] = valid[i] && ent[i].rs1_rdy && ent[i].rs2_rdy;
            sq[i] = valid[i] && squashed(ent[i].al);
        end
        for (int i = 0; i < DEPTH; i++) begin
            rank[i] = '0;
            for (int j = 0; j < DEPTH; j++)
                if (j != i && elig[j] && older(ent[j].age, ent[i].age))
                    rank[i] = rank[i] + CW'(1);
            first[i] = elig[i] && rank[i] == '0;
            second[i] = elig[i] && rank[i] == CW'(1);
            if (first[i]) sel[0] = IW'(i);
            if (second[i]) sel[1] = IW'(i);
        end
        found = {|second, |first};
        go = {found[1] && !sq[sel[1]], found[0] && !sq[sel[0]]};
        rm = first | second | sq;
        for (int i = 0; i < DEPTH; i++)
            n_rm = n_rm + CW'(rm[i]);
    end

    always_comb begin
        f0 = '0;
        f1 = '0;
        we = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (!valid[i]) begin
                f1 = f0;
                f0 = IW'(i);
            end
        for (int l = 0; l < 2; l++) begin
            we[l] = io.disp_valid[l] && io.disp_ready && !io.if_recall;
            new_ent[l] = '0;
            new_ent[l].alu_op = io.disp_alu_op[l];
            new_ent[l].rs1 = io.disp_rs1[l];
            new_ent[l].rs2 = io.disp_rs2[l];
            new_ent[l].rs1_rdy = io.disp_rs1_rdy[l] || woke(io.disp_rs1[l]);
            new_ent[l].rs2_rdy = io.disp_uses_imm[l] || io.disp_rs2_rdy[l] || woke(io.disp_rs2[l]);
            new_ent[l].uses_imm = io.disp_uses_imm[l];
            new_ent[l].imm = io.disp_imm[l];
            new_ent[l].rd = io.disp_rd[l];
            new_ent[l].uses_rd = io.disp_uses_rd[l];
            new_ent[l].al = io.disp_al_addr[l];
        end
        new_ent[0].age = age_ctr;
        new_ent[1].age = age_ctr + GW'(we[0]);
        slot[0] = f0;
        slot[1] = we[0] ? f1 : f0;
        n_disp = CW'(we[0]) + CW'(we[1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            count <= '0;
            age_ctr <= '0;
            io.iss_valid <= '0;
            io.iss_alu_op <= '0;
            io.iss_rs1 <= '0;
            io.iss_rs2 <= '0;
            io.iss_uses_imm <= '0;
            io.iss_imm <= '0;
            io.iss_rd <= '0;
            io.iss_uses_rd <= '0;
            io.iss_al_addr <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (rm[i]) valid[i] <= 1'b0;
                else begin
                    ent[i].rs1_rdy <= ent[i].rs1_rdy || woke(ent[i].rs1);
                    ent[i].rs2_rdy <= ent[i].rs2_rdy || woke(ent[i].rs2);
                end
            for (int l = 0; l < 2; l++)
                if (we[l]) begin
                    valid[slot[l]] <= 1'b1;
                    ent[slot[l]] <= new_ent[l];
                end
            count <= count + n_disp - n_rm;
            age_ctr <= age_ctr + GW'(n_disp);
            io.iss_valid <= go;
            for (int k = 0; k < 2; k++)
                if (go[k]) begin
                    io.iss_alu_op[k] <= ent[sel[k]].alu_op;
                    io.iss_rs1[k] <= ent[sel[k]].rs1;
                    io.iss_rs2[k] <= ent[sel[k]].rs2;
                    io.iss_uses_imm[k] <= ent[sel[k]].uses_imm;
                    io.iss_imm[k] <= ent[sel[k]].imm;
                    io.iss_rd[k] <= ent[sel[k]].rd;
                    io.iss_uses_rd[k] <= ent[sel[k]].uses_rd;
                    io.iss_al_addr[k] <= ent[sel[k]].al;
                end
        end
    end
endmodule
